// File: rtl/execute_stage.sv
// ---------------------------------------------------------------------------
// execute_stage
//   RV64I(+Zba) Execute stage: operand forwarding muxes, 64-bit ALU, branch
//   compare, jump/branch target generation and the Execute/Memory pipeline
//   register.
//
//   Optional build macro: ZBA_EN
//     defined   -> ALUControl codes 5'b10000..5'b10111 perform the Zba ops
//     undefined -> those codes yield 0 and no Zba datapath is built
//
// Ports
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   RD1_E, RD2_E         register-file operands
//   PC_E, ImmExt_E       instruction PC and extended immediate
//   Rd_E                 destination register
//   RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E, is_jalr_E  control
//   ResultSrc_E          00 ALU, 01 memory, 10 PC+4
//   ALUControl_E         ALU operation
//   funct3_E             branch / load-store subtype
//   ForwardA_E/B_E       forwarding selects from the hazard unit
//   ALUResult_M_fwd      Memory-stage forwarding value
//   Result_W             Writeback-stage forwarding value
//   PCSrc_E, PCTarget_E  combinational fetch redirect
//   *_M                  registered Memory-stage outputs
// ---------------------------------------------------------------------------
module execute_stage #(
    parameter int unsigned     XLEN       = 64,
    parameter logic [XLEN-1:0] RESET_PC_M = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] PC_E,
    input  logic [XLEN-1:0] ImmExt_E,
    input  logic [4:0]      Rd_E,
    input  logic            RegWrite_E,
    input  logic            MemWrite_E,
    input  logic            ALUSrc_E,
    input  logic            Branch_E,
    input  logic            Jump_E,
    input  logic            is_jalr_E,
    input  logic [1:0]      ResultSrc_E,
    input  logic [4:0]      ALUControl_E,
    input  logic [2:0]      funct3_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ALUResult_M_fwd,
    input  logic [XLEN-1:0] Result_W,
    output logic            PCSrc_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic [XLEN-1:0] ALUResult_M,
    output logic [XLEN-1:0] WriteData_M,
    output logic [XLEN-1:0] PCPlus4_M,
    output logic [4:0]      Rd_M,
    output logic            RegWrite_M,
    output logic            MemWrite_M,
    output logic [1:0]      ResultSrc_M,
    output logic [2:0]      funct3_M
);

    // ALU operation codes
    localparam logic [4:0] OpAdd     = 5'b00000;
    localparam logic [4:0] OpSub     = 5'b00001;
    localparam logic [4:0] OpAnd     = 5'b00010;
    localparam logic [4:0] OpOr      = 5'b00011;
    localparam logic [4:0] OpXor     = 5'b00100;
    localparam logic [4:0] OpSlt     = 5'b00101;
    localparam logic [4:0] OpSltu    = 5'b00110;
    localparam logic [4:0] OpSll     = 5'b00111;
    localparam logic [4:0] OpSrl     = 5'b01000;
    localparam logic [4:0] OpSra     = 5'b01001;
    localparam logic [4:0] OpAddw    = 5'b01010;
    localparam logic [4:0] OpSubw    = 5'b01011;
    localparam logic [4:0] OpSllw    = 5'b01100;
    localparam logic [4:0] OpSrlw    = 5'b01101;
    localparam logic [4:0] OpSraw    = 5'b01110;
    localparam logic [4:0] OpPassB   = 5'b01111;
`ifdef ZBA_EN
    localparam logic [4:0] OpSh1Add   = 5'b10000;
    localparam logic [4:0] OpSh2Add   = 5'b10001;
    localparam logic [4:0] OpSh3Add   = 5'b10010;
    localparam logic [4:0] OpAddUw    = 5'b10011;
    localparam logic [4:0] OpSh1AddUw = 5'b10100;
    localparam logic [4:0] OpSh2AddUw = 5'b10101;
    localparam logic [4:0] OpSh3AddUw = 5'b10110;
    localparam logic [4:0] OpSlliUw   = 5'b10111;
`endif

    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] src_b_e;
    logic [XLEN-1:0] alu_result_e;
    logic [XLEN-1:0] pc_plus4_e;
    logic [XLEN-1:0] jalr_sum_e;
    logic [31:0]     word_res;
    logic            branch_cond_e;
`ifdef ZBA_EN
    logic [XLEN-1:0] a_uw;
`endif

    // Forwarding muxes; select 11 behaves like 00
    always_comb begin
        case (ForwardA_E)
            2'b01:   src_a_e = Result_W;
            2'b10:   src_a_e = ALUResult_M_fwd;
            default: src_a_e = RD1_E;
        endcase
        case (ForwardB_E)
            2'b01:   write_data_e = Result_W;
            2'b10:   write_data_e = ALUResult_M_fwd;
            default: write_data_e = RD2_E;
        endcase
        src_b_e = ALUSrc_E ? ImmExt_E : write_data_e;
    end

    // ALU
    always_comb begin
        alu_result_e = '0;
        word_res     = '0;
`ifdef ZBA_EN
        a_uw         = {32'b0, src_a_e[31:0]};
`endif
        case (ALUControl_E)
            OpAdd:   alu_result_e = src_a_e + src_b_e;
            OpSub:   alu_result_e = src_a_e - src_b_e;
            OpAnd:   alu_result_e = src_a_e & src_b_e;
            OpOr:    alu_result_e = src_a_e | src_b_e;
            OpXor:   alu_result_e = src_a_e ^ src_b_e;
            OpSlt:   alu_result_e = {63'b0, $signed(src_a_e) < $signed(src_b_e)};
            OpSltu:  alu_result_e = {63'b0, src_a_e < src_b_e};
            OpSll:   alu_result_e = src_a_e << src_b_e[5:0];
            OpSrl:   alu_result_e = src_a_e >> src_b_e[5:0];
            OpSra:   alu_result_e = $signed(src_a_e) >>> src_b_e[5:0];
            OpAddw, OpSubw, OpSllw, OpSrlw, OpSraw: begin
                case (ALUControl_E)
                    OpAddw:  word_res = src_a_e[31:0] + src_b_e[31:0];
                    OpSubw:  word_res = src_a_e[31:0] - src_b_e[31:0];
                    OpSllw:  word_res = src_a_e[31:0] << src_b_e[4:0];
                    OpSrlw:  word_res = src_a_e[31:0] >> src_b_e[4:0];
                    default: word_res = $signed(src_a_e[31:0]) >>> src_b_e[4:0];
                endcase
                alu_result_e = {{32{word_res[31]}}, word_res};
            end
            OpPassB: alu_result_e = src_b_e;
`ifdef ZBA_EN
            OpSh1Add:   alu_result_e = (src_a_e << 1) + src_b_e;
            OpSh2Add:   alu_result_e = (src_a_e << 2) + src_b_e;
            OpSh3Add:   alu_result_e = (src_a_e << 3) + src_b_e;
            OpAddUw:    alu_result_e = a_uw + src_b_e;
            OpSh1AddUw: alu_result_e = (a_uw << 1) + src_b_e;
            OpSh2AddUw: alu_result_e = (a_uw << 2) + src_b_e;
            OpSh3AddUw: alu_result_e = (a_uw << 3) + src_b_e;
            OpSlliUw:   alu_result_e = a_uw << src_b_e[5:0];
`endif
            default: alu_result_e = '0;
        endcase
    end

    // Branch compare always uses the forwarded register operands, never the immediate
    always_comb begin
        case (funct3_E)
            3'b000:  branch_cond_e = (src_a_e == write_data_e);
            3'b001:  branch_cond_e = (src_a_e != write_data_e);
            3'b100:  branch_cond_e = ($signed(src_a_e) < $signed(write_data_e));
            3'b101:  branch_cond_e = ($signed(src_a_e) >= $signed(write_data_e));
            3'b110:  branch_cond_e = (src_a_e < write_data_e);
            3'b111:  branch_cond_e = (src_a_e >= write_data_e);
            default: branch_cond_e = 1'b0;
        endcase
    end

    always_comb begin
        jalr_sum_e = src_a_e + ImmExt_E;
        pc_plus4_e = PC_E + 64'd4;
        PCSrc_E    = Jump_E | (Branch_E & branch_cond_e);
        PCTarget_E = is_jalr_E ? {jalr_sum_e[XLEN-1:1], 1'b0} : (PC_E + ImmExt_E);
    end

    // Execute/Memory pipeline register
    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic [XLEN-1:0] write_data_d, write_data_q;
    logic [XLEN-1:0] pc_plus4_d,   pc_plus4_q;
    logic [4:0]      rd_d,         rd_q;
    logic            reg_write_d,  reg_write_q;
    logic            mem_write_d,  mem_write_q;
    logic [1:0]      result_src_d, result_src_q;
    logic [2:0]      funct3_d,     funct3_q;

    always_comb begin
        alu_result_d = alu_result_e;
        write_data_d = write_data_e;
        pc_plus4_d   = pc_plus4_e;
        rd_d         = Rd_E;
        reg_write_d  = RegWrite_E;
        mem_write_d  = MemWrite_E;
        result_src_d = ResultSrc_E;
        funct3_d     = funct3_E;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_result_q <= '0;
            write_data_q <= '0;
            pc_plus4_q   <= RESET_PC_M;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            funct3_q     <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            write_data_q <= write_data_d;
            pc_plus4_q   <= pc_plus4_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            funct3_q     <= funct3_d;
        end
    end

    assign ALUResult_M = alu_result_q;
    assign WriteData_M = write_data_q;
    assign PCPlus4_M   = pc_plus4_q;
    assign Rd_M        = rd_q;
    assign RegWrite_M  = reg_write_q;
    assign MemWrite_M  = mem_write_q;
    assign ResultSrc_M = result_src_q;
    assign funct3_M    = funct3_q;

endmodule

// File: tb/tb_execute_stage.sv
// ---------------------------------------------------------------------------
// tb_execute_stage
//   Directed, self-checking bench for execute_stage. Inputs change #1 after a
//   rising edge; combinational outputs are sampled #1 after that and
//   registered outputs #1 after the following rising edge.
// ---------------------------------------------------------------------------
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] RD1_E, RD2_E, PC_E, ImmExt_E;
    logic [4:0]  Rd_E;
    logic        RegWrite_E, MemWrite_E, ALUSrc_E, Branch_E, Jump_E, is_jalr_E;
    logic [1:0]  ResultSrc_E;
    logic [4:0]  ALUControl_E;
    logic [2:0]  funct3_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [63:0] ALUResult_M_fwd, Result_W;
    logic        PCSrc_E;
    logic [63:0] PCTarget_E, ALUResult_M, WriteData_M, PCPlus4_M;
    logic [4:0]  Rd_M;
    logic        RegWrite_M, MemWrite_M;
    logic [1:0]  ResultSrc_M;
    logic [2:0]  funct3_M;

    int tests = 0;
    int fails = 0;

    execute_stage #(
        .XLEN      (64),
        .RESET_PC_M(64'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RD1_E          (RD1_E),
        .RD2_E          (RD2_E),
        .PC_E           (PC_E),
        .ImmExt_E       (ImmExt_E),
        .Rd_E           (Rd_E),
        .RegWrite_E     (RegWrite_E),
        .MemWrite_E     (MemWrite_E),
        .ALUSrc_E       (ALUSrc_E),
        .Branch_E       (Branch_E),
        .Jump_E         (Jump_E),
        .is_jalr_E      (is_jalr_E),
        .ResultSrc_E    (ResultSrc_E),
        .ALUControl_E   (ALUControl_E),
        .funct3_E       (funct3_E),
        .ForwardA_E     (ForwardA_E),
        .ForwardB_E     (ForwardB_E),
        .ALUResult_M_fwd(ALUResult_M_fwd),
        .Result_W       (Result_W),
        .PCSrc_E        (PCSrc_E),
        .PCTarget_E     (PCTarget_E),
        .ALUResult_M    (ALUResult_M),
        .WriteData_M    (WriteData_M),
        .PCPlus4_M      (PCPlus4_M),
        .Rd_M           (Rd_M),
        .RegWrite_M     (RegWrite_M),
        .MemWrite_M     (MemWrite_M),
        .ResultSrc_M    (ResultSrc_M),
        .funct3_M       (funct3_M)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        RD1_E = '0; RD2_E = '0; PC_E = '0; ImmExt_E = '0; Rd_E = '0;
        RegWrite_E = 0; MemWrite_E = 0; ALUSrc_E = 0; Branch_E = 0; Jump_E = 0;
        is_jalr_E = 0; ResultSrc_E = '0; ALUControl_E = '0; funct3_E = '0;
        ForwardA_E = '0; ForwardB_E = '0; ALUResult_M_fwd = '0; Result_W = '0;
    endtask

    // Advance one edge and settle so registered outputs can be sampled
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an ALU op on RD1/RD2 (or imm when use_imm) and check ALUResult_M
    task automatic alu_vec(input string tag, input logic [4:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic use_imm,
                           input logic [63:0] exp);
        clear_inputs();
        ALUControl_E = op;
        RD1_E        = a;
        ALUSrc_E     = use_imm;
        if (use_imm) ImmExt_E = b;
        else         RD2_E    = b;
        tick();
        check(tag, ALUResult_M, exp);
    endtask

    initial begin
        clear_inputs();
        #1 rst = 1'b1;
        #1;
        // Reset state, no clock edge yet
        check("rst_alu", ALUResult_M, 64'h0);
        check("rst_wd", WriteData_M, 64'h0);
        check("rst_pc4", PCPlus4_M, 64'h0);
        check("rst_ctl", {54'b0, Rd_M, RegWrite_M, MemWrite_M, ResultSrc_M, funct3_M}, 64'h0);
        tick();
        check("rst_held", {63'b0, RegWrite_M}, 64'h0);
        rst = 1'b0;

        // Forward A from Memory stage
        clear_inputs();
        ALUControl_E = 5'b00000; RD1_E = 64'd5; RD2_E = 64'd7;
        ForwardA_E = 2'b10; ALUResult_M_fwd = 64'd100;
        RegWrite_E = 1; Rd_E = 5'd9; funct3_E = 3'b011; MemWrite_E = 1;
        tick();
        check("fwdA_m_alu", ALUResult_M, 64'd107);
        check("fwdA_m_wd", WriteData_M, 64'd7);
        check("ctl_pipe", {56'b0, Rd_M, RegWrite_M, MemWrite_M, funct3_M}, {56'b0, 5'd9, 2'b11, 3'b011});

        // Forward B from Writeback stage; ForwardA=11 selects RD1
        clear_inputs();
        ALUControl_E = 5'b00000; RD1_E = 64'd1; RD2_E = 64'd50; Result_W = 64'd20;
        ForwardA_E = 2'b11; ForwardB_E = 2'b01; ALUResult_M_fwd = 64'd999;
        tick();
        check("fwdB_w_alu", ALUResult_M, 64'd21);
        check("fwdB_w_wd", WriteData_M, 64'd20);

        alu_vec("sub", 5'b00001, 64'd10, 64'd3, 0, 64'd7);
        alu_vec("xor", 5'b00100, 64'hF0F0, 64'h0FF0, 0, 64'hFF00);
        alu_vec("slt", 5'b00101, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd1);
        alu_vec("sltu", 5'b00110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'd0);
        alu_vec("sll63", 5'b00111, 64'd1, 64'd63, 1, 64'h8000_0000_0000_0000);
        alu_vec("srl", 5'b01000, 64'h8000_0000_0000_0000, 64'd4, 1, 64'h0800_0000_0000_0000);
        alu_vec("sra", 5'b01001, 64'h8000_0000_0000_0000, 64'd4, 1, 64'hF800_0000_0000_0000);
        alu_vec("addw", 5'b01010, 64'h7FFF_FFFF, 64'd1, 0, 64'hFFFF_FFFF_8000_0000);
        alu_vec("subw", 5'b01011, 64'hFFFF_FFFF_0000_0000, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_vec("sraw", 5'b01110, 64'h8000_0000, 64'd31, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        alu_vec("srlw_sh5", 5'b01101, 64'h8000_0000, 64'd63, 1, 64'd1);
        alu_vec("passb", 5'b01111, 64'd77, 64'h1234_5000, 1, 64'h1234_5000);
        alu_vec("undef", 5'b11000, 64'd5, 64'd6, 0, 64'd0);
`ifdef ZBA_EN
        alu_vec("sh3add_uw", 5'b10110, 64'hFFFF_FFFF_0000_0002, 64'd1, 0, 64'd17);
        alu_vec("sh1add", 5'b10000, 64'h8000_0000_0000_0003, 64'd1, 0, 64'd7);
`else
        alu_vec("sh3add_uw", 5'b10110, 64'hFFFF_FFFF_0000_0002, 64'd1, 0, 64'd0);
        alu_vec("sh1add", 5'b10000, 64'h8000_0000_0000_0003, 64'd1, 0, 64'd0);
`endif

        // Branch BLT taken (signed)
        clear_inputs();
        Branch_E = 1; funct3_E = 3'b100; RD1_E = 64'hFFFF_FFFF_FFFF_FFFF; RD2_E = 64'd1;
        PC_E = 64'h1000; ImmExt_E = 64'hFFFF_FFFF_FFFF_FFF0; ALUSrc_E = 1;
        #1;
        check("blt_src", {63'b0, PCSrc_E}, 64'd1);
        check("blt_tgt", PCTarget_E, 64'hFF0);
        funct3_E = 3'b110;
        #1;
        check("bltu_src", {63'b0, PCSrc_E}, 64'd0);
        funct3_E = 3'b111;
        #1;
        check("bgeu_src", {63'b0, PCSrc_E}, 64'd1);
        funct3_E = 3'b101;
        #1;
        check("bge_src", {63'b0, PCSrc_E}, 64'd0);

        // BEQ / BNE / reserved funct3 on equal operands
        RD2_E = 64'hFFFF_FFFF_FFFF_FFFF; funct3_E = 3'b000;
        #1;
        check("beq_src", {63'b0, PCSrc_E}, 64'd1);
        funct3_E = 3'b001;
        #1;
        check("bne_src", {63'b0, PCSrc_E}, 64'd0);
        funct3_E = 3'b010;
        #1;
        check("f3_010_src", {63'b0, PCSrc_E}, 64'd0);

        // Jump with Branch whose condition fails: still redirects to PC+imm
        Jump_E = 1;
        #1;
        check("jb_src", {63'b0, PCSrc_E}, 64'd1);
        check("jb_tgt", PCTarget_E, 64'hFF0);

        // JALR with forwarded base; target bit0 cleared
        clear_inputs();
        Jump_E = 1; is_jalr_E = 1; ResultSrc_E = 2'b10; RegWrite_E = 1;
        ForwardA_E = 2'b01; Result_W = 64'h2003; RD1_E = 64'h5555;
        ImmExt_E = 64'd4; PC_E = 64'h400; ALUSrc_E = 1;
        #1;
        check("jalr_src", {63'b0, PCSrc_E}, 64'd1);
        check("jalr_tgt", PCTarget_E, 64'h2006);
        tick();
        check("jalr_pc4", PCPlus4_M, 64'h404);
        check("jalr_rsrc", {62'b0, ResultSrc_M}, 64'd2);

        // PC+4 wraps at 2^64
        clear_inputs();
        PC_E = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        check("pc4_wrap", PCPlus4_M, 64'h0);

        // Reset mid-operation: outputs clear between edges, no clock needed
        clear_inputs();
        ALUControl_E = 5'b00000; RD1_E = 64'd3; RD2_E = 64'd4; RegWrite_E = 1;
        PC_E = 64'h100; Rd_E = 5'd7;
        tick();
        check("pre_rst_rw", {63'b0, RegWrite_M}, 64'd1);
        check("pre_rst_alu", ALUResult_M, 64'd7);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rw", {63'b0, RegWrite_M}, 64'd0);
        check("mid_rst_alu", ALUResult_M, 64'd0);
        check("mid_rst_pc4", PCPlus4_M, 64'd0);
        check("mid_rst_rd", {59'b0, Rd_M}, 64'd0);
        check("mid_rst_pcsrc_comb", PCTarget_E, 64'h100);
        #1 rst = 1'b0;
        RD1_E = 64'd30; RD2_E = 64'd12;
        tick();
        check("post_rst_alu", ALUResult_M, 64'd42);
        check("post_rst_pc4", PCPlus4_M, 64'h104);
        check("post_rst_rw", {63'b0, RegWrite_M}, 64'd1);

        // Bubble propagates as no write
        clear_inputs();
        tick();
        check("bubble_rw", {62'b0, RegWrite_M, MemWrite_M}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
